adder_arbiter: RTL

//   Shares one 64-bit adder datapath among NUM_REQ requesters (PC+4, branch target, AGU, ALU).

---
 rtl/adder_arb_pkg.sv | 13 +
 rtl/adder_arbiter_rr_arbiter.sv | 37 +++
 rtl/adder_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and default sizes for the shared-adder arbiter.
// Holds the output-register state encoding.
package adder_arb_pkg;

    localparam int DEF_WIDTH   = 64;
    localparam int DEF_NUM_REQ = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Rotating-priority arbiter: scans from ptr upward (mod NUM_REQ).
// Produces a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    logic [ID_W:0] slot;

    // Walk from the farthest slot back to ptr so the nearest request wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        slot    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            slot = {1'b0, ptr} + (ID_W + 1)'(k);
            if (slot >= (ID_W + 1)'(NUM_REQ)) begin
                slot = slot - (ID_W + 1)'(NUM_REQ);
            end
            if (req[slot[ID_W-1:0]]) begin
                gnt_idx = slot[ID_W-1:0];
                gnt_any = 1'b1;
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// One shared WIDTH-bit adder, round-robin among NUM_REQ requesters.
// Define ADDER_ARB_SUB_EN to add the req_sub port (a - b per request).
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int WIDTH   = DEF_WIDTH,
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
`ifdef ADDER_ARB_SUB_EN
    input  logic [NUM_REQ-1:0]       req_sub,
`endif
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_carry,
    output logic [ID_W-1:0]          rsp_id
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              carry_q, carry_d;
    logic [ID_W-1:0]   id_q, id_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               can_accept;
    logic               accept;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_eff;
    logic               cin;
    logic [WIDTH:0]     sum;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Handshake: ready only to the grantee when the output reg can take it
    always_comb begin
        can_accept = (state_q == EMPTY) | rsp_ready;
        accept     = rst_n & can_accept & gnt_any;
        req_ready  = accept ? gnt : '0;
    end

    // Operand mux and the shared adder (subtract is a + ~b + 1)
    always_comb begin
        a_sel = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
        b_eff = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
        cin   = 1'b0;
`ifdef ADDER_ARB_SUB_EN
        if (req_sub[gnt_idx]) begin
            b_eff = ~b_eff;
            cin   = 1'b1;
        end
`endif
        sum = {1'b0, a_sel} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    end

    // Next state for the output register, pointer and FSM
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        carry_d  = carry_q;
        id_d     = id_q;
        if (accept) begin
            state_d = FULL;
            data_d  = sum[WIDTH-1:0];
            carry_d = sum[WIDTH];
            id_d    = gnt_idx;
            if (gnt_idx == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + 1'b1;
            end
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    // State and result registers; reset drops any in-flight result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            data_q   <= '0;
            carry_q  <= 1'b0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            carry_q  <= carry_d;
            id_q     <= id_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = data_q;
    assign rsp_carry = carry_q;
    assign rsp_id    = id_q;

endmodule
